copro_resp: RTL



---
 rtl/copro_resp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/copro_resp.sv
// LM32 user-instruction coprocessor responder: float sign/compare ops and an iterative multiply.
// Optional build macro COPRO_MULH_EN adds MULHU (function 5) and widens the accumulator to 64 bits.
module copro_resp #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        copro_valid,
    input  logic        copro_accept,
    input  logic [10:0] copro_opcode,
    input  logic [31:0] copro_op0,
    input  logic [31:0] copro_op1,
    output logic [31:0] copro_result,
    output logic        copro_complete,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam int B     = MUL_BITS_PER_CYCLE;
    localparam int ITERS = 32 / B;
    localparam int CNT_W = $clog2(ITERS);
`ifdef COPRO_MULH_EN
    localparam int ACC_W = 64;
`else
    localparam int ACC_W = 32;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   mcand_sh;
    logic [31:0]        mplier;
    logic [CNT_W-1:0]   cnt;
`ifdef COPRO_MULH_EN
    logic               mul_high;
`endif

    logic [3:0]       func;
    logic             is_mul;
    logic             nan_any, zero_both, mag_lt, mag_gt, f_lt, f_eq;
    logic [31:0]      single_res, mul_res;
    logic [ACC_W-1:0] acc_next;
    wire              unused_opcode_hi = ^copro_opcode[10:4];

    assign func      = copro_opcode[3:0];
    assign state_dbg = state;

    // NaN: exponent all ones with a non-zero mantissa; sign ignored for the zero test.
    assign nan_any   = (&copro_op0[30:23] && |copro_op0[22:0]) ||
                       (&copro_op1[30:23] && |copro_op1[22:0]);
    assign zero_both = ~|copro_op0[30:0] && ~|copro_op1[30:0];
    assign mag_lt    = copro_op0[30:0] < copro_op1[30:0];
    assign mag_gt    = copro_op0[30:0] > copro_op1[30:0];

    always_comb begin
        f_lt = 1'b0;
        if (!nan_any && !zero_both) begin
            if (copro_op0[31] != copro_op1[31]) f_lt = copro_op0[31];
            else if (!copro_op0[31])            f_lt = mag_lt;
            else                                f_lt = mag_gt;
        end
        f_eq = !nan_any && (zero_both || (copro_op0 == copro_op1));
    end

    always_comb begin
        single_res = 32'h0000_0000;
        case (func)
            4'd0:    single_res = copro_op0 ^ 32'h8000_0000;
            4'd1:    single_res = copro_op0 & 32'h7FFF_FFFF;
            4'd2:    single_res = {31'b0, f_lt};
            4'd3:    single_res = {31'b0, f_eq};
            default: single_res = 32'h0000_0000;
        endcase
    end

`ifdef COPRO_MULH_EN
    assign is_mul = (func == 4'd4) || (func == 4'd5);
`else
    assign is_mul = (func == 4'd4);
`endif

    // The multiplicand is pre-shifted each iteration, so the partial product lands in place.
    assign acc_next = acc + mcand_sh * ACC_W'(mplier[B-1:0]);

`ifdef COPRO_MULH_EN
    assign mul_res = mul_high ? acc_next[63:32] : acc_next[31:0];
`else
    assign mul_res = acc_next[31:0];
`endif

    // Handshake: a request is taken only when copro_valid is high in IDLE; the result is
    // held with copro_complete high until copro_accept is seen in DONE, which returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            copro_result   <= 32'h0000_0000;
            copro_complete <= 1'b0;
            busy           <= 1'b0;
            acc            <= '0;
            mcand_sh       <= '0;
            mplier         <= 32'h0000_0000;
            cnt            <= '0;
`ifdef COPRO_MULH_EN
            mul_high       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (copro_valid) begin
                        busy <= 1'b1;
                        if (is_mul) begin
                            acc      <= '0;
                            mcand_sh <= ACC_W'(copro_op0);
                            mplier   <= copro_op1;
                            cnt      <= CNT_W'(ITERS - 1);
`ifdef COPRO_MULH_EN
                            mul_high <= (func == 4'd5);
`endif
                            state    <= MUL;
                        end else begin
                            copro_result   <= single_res;
                            copro_complete <= 1'b1;
                            state          <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << B;
                    mplier   <= mplier >> B;
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0) begin
                        copro_result   <= mul_res;
                        copro_complete <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    if (copro_accept) begin
                        copro_complete <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
